control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle processor control unit sequencing mv/mvi/add/sub over a shared bus
//
// Purpose:
//   Four-step sequencer (T0..T3) for a small bus-based datapath. T0 fetches
//   the instruction into the instruction register; T1..T3 steer the register
//   file, the A/G accumulator registers and the DIN port onto the shared bus.
//   State advances on the falling edge of CLKb; every output is decoded
//   combinationally from the current state and the registered instruction.
//
// Optional feature:
//   CU_MVNZ_EN - when defined, adds the GNZ input and decodes opcode 0100
//                (mvnz: move Ry to Rx only when G is non-zero). When left
//                undefined, GNZ does not exist and opcode 0100 is a NOP.
//
// Ports:
//   CLKb    in   1   clock, state changes on the falling edge
//   RST     in   1   synchronous active-high reset
//   Run     in   1   start-fetch request, only looked at in T0
//   IR      in   N   registered instruction {opcode[N-1:N-4], Rx[5:3], Ry[2:0]}
//   GNZ     in   1   G is non-zero (CU_MVNZ_EN builds only)
//   IRin    out  1   instruction register load enable
//   Rin     out  8   one-hot register-file write select
//   Rout    out  8   one-hot register-file bus-drive select
//   Ain     out  1   A register load
//   Gin     out  1   G register load
//   Gout    out  1   G drives the bus
//   DINout  out  1   DIN drives the bus
//   AddSub  out  1   ALU operation, 1 = subtract
//   Done    out  1   instruction complete (one cycle per instruction)

module control_unit #(
   parameter int N = 10
) (
   input  logic         CLKb,
   input  logic         RST,
   input  logic         Run,
   input  logic [N-1:0] IR,
`ifdef CU_MVNZ_EN
   input  logic         GNZ,
`endif
   output logic         IRin,
   output logic [7:0]   Rin,
   output logic [7:0]   Rout,
   output logic         Ain,
   output logic         Gin,
   output logic         Gout,
   output logic         DINout,
   output logic         AddSub,
   output logic         Done
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
`ifdef CU_MVNZ_EN
   localparam logic [3:0] OP_MVNZ = 4'b0100;
`endif

   state_t      r_state;
   state_t      w_next_state;

   logic [3:0]  w_opcode;
   logic [2:0]  w_rx;
   logic [2:0]  w_ry;
   logic [7:0]  w_rx_oh;
   logic [7:0]  w_ry_oh;
   logic        w_is_alu;

   assign w_opcode = IR[N-1:N-4];
   assign w_rx     = IR[5:3];
   assign w_ry     = IR[2:0];
   assign w_rx_oh  = 8'd1 << w_rx;
   assign w_ry_oh  = 8'd1 << w_ry;
   assign w_is_alu = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

   // State register: reset is sampled on the same falling edge that
   // advances the sequencer, so an interrupted instruction simply vanishes.
   always_ff @(negedge CLKb) begin
      if (RST) begin
         r_state <= T0;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode. Run is only consulted in T0, so a held Run cannot
   // restart an instruction that is already in flight.
   always_comb begin
      w_next_state = T0;
      unique case (r_state)
         T0: w_next_state = Run ? T1 : T0;
         T1: w_next_state = w_is_alu ? T2 : T0;
         T2: w_next_state = T3;
         T3: w_next_state = T0;
         default: w_next_state = T0;
      endcase
   end

   // Output decode. Each step drives at most one bus source (a single Rout
   // bit, Gout or DINout). Reset blanks everything, including the fetch.
   always_comb begin
      IRin   = 1'b0;
      Rin    = 8'd0;
      Rout   = 8'd0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
      if (!RST) begin
         unique case (r_state)
            T0: begin
               IRin = Run;
            end
            T1: begin
               case (w_opcode)
                  OP_MV: begin
                     Rout = w_ry_oh;
                     Rin  = w_rx_oh;
                     Done = 1'b1;
                  end
                  OP_MVI: begin
                     DINout = 1'b1;
                     Rin    = w_rx_oh;
                     Done   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     Rout = w_rx_oh;
                     Ain  = 1'b1;
                  end
`ifdef CU_MVNZ_EN
                  OP_MVNZ: begin
                     // Conditional move still completes when skipped.
                     if (GNZ) begin
                        Rout = w_ry_oh;
                        Rin  = w_rx_oh;
                     end
                     Done = 1'b1;
                  end
`endif
                  default: begin
                     Done = 1'b1;
                  end
               endcase
            end
            T2: begin
               Rout   = w_ry_oh;
               Gin    = 1'b1;
               AddSub = (w_opcode == OP_SUB);
            end
            T3: begin
               Gout = 1'b1;
               Rin  = w_rx_oh;
               Done = 1'b1;
            end
            default: begin
               Done = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

   localparam int N = 10;
   typedef logic [22:0] vec_t;

   logic         CLKb = 1'b1;
   logic         RST;
   logic         Run;
   logic [N-1:0] IR;
   logic         GNZ;
   logic         IRin;
   logic [7:0]   Rin;
   logic [7:0]   Rout;
   logic         Ain;
   logic         Gin;
   logic         Gout;
   logic         DINout;
   logic         AddSub;
   logic         Done;

   int           passed = 0;
   int           total  = 0;
   int           cyc    = 0;
   int           done_cyc_q[$];
   vec_t         exp_q[$];
   vec_t         w_obs;

   always #5 CLKb = ~CLKb;
   always @(negedge CLKb) cyc <= cyc + 1;

   control_unit #(.N(N)) dut (
      .CLKb   (CLKb),
      .RST    (RST),
      .Run    (Run),
      .IR     (IR),
`ifdef CU_MVNZ_EN
      .GNZ    (GNZ),
`endif
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .Ain    (Ain),
      .Gin    (Gin),
      .Gout   (Gout),
      .DINout (DINout),
      .AddSub (AddSub),
      .Done   (Done)
   );

   assign w_obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};

   function automatic vec_t pk(logic irin, logic [7:0] rin, logic [7:0] rout, logic ain,
                               logic gin, logic gout, logic din, logic as, logic done);
      return {irin, rin, rout, ain, gin, gout, din, as, done};
   endfunction

   function automatic logic [7:0] oh(logic [2:0] idx);
      logic [7:0] one;
      one = 8'd1;
      return one << idx;
   endfunction

   // Reference: the list of per-cycle control words that follow the fetch.
   task automatic build(input logic [N-1:0] ir, input logic gnz);
      logic [3:0] op;
      logic [2:0] rx;
      logic [2:0] ry;
      op = ir[N-1:N-4];
      rx = ir[5:3];
      ry = ir[2:0];
      exp_q.delete();
      if (op == 4'd0) begin
         exp_q.push_back(pk(0, oh(rx), oh(ry), 0, 0, 0, 0, 0, 1));
      end else if (op == 4'd1) begin
         exp_q.push_back(pk(0, oh(rx), 8'd0, 0, 0, 0, 1, 0, 1));
      end else if (op == 4'd2 || op == 4'd3) begin
         exp_q.push_back(pk(0, 8'd0, oh(rx), 1, 0, 0, 0, 0, 0));
         exp_q.push_back(pk(0, 8'd0, oh(ry), 0, 1, 0, 0, (op == 4'd3), 0));
         exp_q.push_back(pk(0, oh(rx), 8'd0, 0, 0, 1, 0, 0, 1));
`ifdef CU_MVNZ_EN
      end else if (op == 4'd4) begin
         if (gnz) exp_q.push_back(pk(0, oh(rx), oh(ry), 0, 0, 0, 0, 0, 1));
         else     exp_q.push_back(pk(0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 1));
`endif
      end else begin
         exp_q.push_back(pk(0, 8'd0, 8'd0, 0, 0, 0, 0, 0, 1));
      end
   endtask

   task automatic step(input logic rst, input logic run, input logic [N-1:0] ir, input logic gnz);
      @(negedge CLKb);
      #1;
      RST = rst;
      Run = run;
      IR  = ir;
      GNZ = gnz;
      #1;
   endtask

   task automatic chk(input string tag, input vec_t exp);
      total++;
      assert (w_obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
      total++;
      assert ($countones({Rout, Gout, DINout}) <= 1) passed++;
      else $error("FAIL %s_bus observed=%0d drivers expected=at most 1", tag, $countones({Rout, Gout, DINout}));
      if (Done === 1'b1) done_cyc_q.push_back(cyc);
   endtask

   task automatic exec(input logic [N-1:0] ir, input logic gnz, input bit hold_run, input string tag);
      logic [N-1:0] junk;
      int           dn;
      junk = N'($urandom);
      build(ir, gnz);
      step(0, 1, junk, gnz);
      chk({tag, "_t0"}, pk(1, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
      dn = 0;
      foreach (exp_q[i]) begin
         step(0, hold_run ? 1'b1 : 1'($urandom), ir, gnz);
         if (Done === 1'b1) dn++;
         chk($sformatf("%s_c%0d", tag, i + 1), exp_q[i]);
      end
      total++;
      assert (dn == 1) passed++;
      else $error("FAIL %s_done_count observed=%0d expected=1", tag, dn);
   endtask

   initial begin
      logic [N-1:0] ir;
      logic         g;
      RST = 1'b1;
      Run = 1'b1;
      IR  = '0;
      GNZ = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step(1, 1, N'($urandom), 0);
         chk("reset_hold", '0);
      end

      for (int i = 0; i < 5; i++) begin
         step(0, 0, N'($urandom), 0);
         chk("idle", '0);
      end

      exec(10'b0000_011_101, 0, 0, "mv");
      exec(10'b0001_010_000, 0, 0, "mvi");
      exec(10'b0011_001_110, 0, 0, "sub");
      exec(10'b0000_100_100, 0, 0, "mv_same");
      exec(10'b1111_000_111, 0, 0, "nop");

      done_cyc_q.delete();
      exec(10'b0010_111_000, 0, 1, "add_b2b_a");
      exec(10'b0010_000_111, 0, 1, "add_b2b_b");
      total++;
      assert (done_cyc_q.size() == 2 && done_cyc_q[1] - done_cyc_q[0] == 4) passed++;
      else $error("FAIL b2b_done_spacing observed=%0d pulses expected=2 pulses 4 apart", done_cyc_q.size());

      exec(10'b0100_110_011, 0, 0, "mvnz_g0");
      exec(10'b0100_110_011, 1, 0, "mvnz_g1");

      // Reset arriving in T2 with Run held high.
      ir = 10'b0010_101_010;
      step(0, 1, N'($urandom), 0);
      chk("rst_mid_t0", pk(1, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0));
      step(0, 1, ir, 0);
      chk("rst_mid_t1", pk(0, 8'd0, oh(3'd5), 1, 0, 0, 0, 0, 0));
      step(1, 1, ir, 0);
      chk("rst_mid_t2", '0);
      step(1, 1, ir, 0);
      chk("rst_mid_after", '0);
      step(0, 0, ir, 0);
      chk("rst_mid_back_t0", '0);

      for (int k = 0; k < 40; k++) begin
         ir = N'($urandom);
         ir[N-1:N-4] = 4'($urandom_range(0, 5)) | (($urandom_range(0, 3) == 0) ? 4'd8 : 4'd0);
         g  = 1'($urandom);
         exec(ir, g, 0, $sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
